fetch_sequencer: RTL and testbench

//  Owns the program counter and sequences instruction fetch for the MIPS core.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/fetch_sequencer_if.sv | 28 ++
 rtl/pc_next_mux.sv | 32 +++
 rtl/fetch_sequencer.sv | 119 +++++++++++
 tb/tb_fetch_sequencer.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared fetch-path types and constants for the MIPS core.
// Optional single-step mode: FETCH_STEP_EN adds the STEP_WAIT state.
package mips_pkg;

  localparam int unsigned     PC_W_DEF    = 10;
  localparam int unsigned     OP_W        = 6;
  localparam logic [OP_W-1:0] HALT_OP_DEF = 6'h3F;

`ifdef FETCH_STEP_EN
  typedef enum logic [2:0] {
    ST_BOOT,
    ST_RUN,
    ST_REDIR,
    ST_HALT,
    ST_STEP_WAIT
  } fetch_state_e;
`else
  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_REDIR,
    ST_HALT
  } fetch_state_e;
`endif

endpackage

// File: rtl/fetch_sequencer_if.sv
// Control/ROM-side signals of the fetch sequencer.
// The master modport is the sequencer; slave is decode/execute control plus the ROM.
interface fetch_sequencer_if #(
  parameter int unsigned PC_W = mips_pkg::PC_W_DEF
);
  logic                      hazard;
  logic                      branch_taken;
  logic [PC_W-1:0]           branch_pc;
  logic                      jump_req;
  logic [PC_W-1:0]           jump_pc;
  logic [mips_pkg::OP_W-1:0] opcode;
  logic                      step;
  logic [PC_W-1:0]           pc;
  logic [PC_W-1:0]           pc_plus1;
  logic                      fetch_valid;
  logic                      flush;
  logic                      halted;

  modport master (
    input  hazard, branch_taken, branch_pc, jump_req, jump_pc, opcode, step,
    output pc, pc_plus1, fetch_valid, flush, halted
  );

  modport slave (
    output hazard, branch_taken, branch_pc, jump_req, jump_pc, opcode, step,
    input  pc, pc_plus1, fetch_valid, flush, halted
  );
endinterface

// File: rtl/pc_next_mux.sv
// Next-PC priority select: branch > jump > hold > increment.
module pc_next_mux #(
  parameter int unsigned PC_W = 10
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic            branch_en_i,
  input  logic            branch_taken_i,
  input  logic [PC_W-1:0] branch_pc_i,
  input  logic            jump_en_i,
  input  logic            jump_req_i,
  input  logic [PC_W-1:0] jump_pc_i,
  input  logic            hold_i,
  output logic [PC_W-1:0] pc_next_o,
  output logic [PC_W-1:0] pc_plus1_o,
  output logic            redirect_o
);

  always_comb begin
    pc_plus1_o = pc_i + PC_W'(1);
    redirect_o = (branch_en_i && branch_taken_i) || (jump_en_i && jump_req_i);
    if (branch_en_i && branch_taken_i) begin
      pc_next_o = branch_pc_i;
    end else if (jump_en_i && jump_req_i) begin
      pc_next_o = jump_pc_i;
    end else if (hold_i) begin
      pc_next_o = pc_i;
    end else begin
      pc_next_o = pc_plus1_o;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter owner and instruction-fetch sequencer for the MIPS core.
// Define FETCH_STEP_EN to gate every RUN advance behind a step pulse.
module fetch_sequencer #(
  parameter int unsigned               PC_W     = mips_pkg::PC_W_DEF,
  parameter logic [PC_W-1:0]           RESET_PC = '0,
  parameter logic [mips_pkg::OP_W-1:0] HALT_OP  = mips_pkg::HALT_OP_DEF
) (
  input logic                clk,
  input logic                reset,
  fetch_sequencer_if.master  bus
);
  import mips_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_next, pc_plus1;
  logic            fetch_valid_q, fetch_valid_d;
  logic            halted_q, halted_d;
  logic            branch_en, jump_en, hold, redirect, flush;
  logic            halt_hit;

  pc_next_mux #(.PC_W(PC_W)) u_pc_next_mux (
    .pc_i          (pc_q),
    .branch_en_i   (branch_en),
    .branch_taken_i(bus.branch_taken),
    .branch_pc_i   (bus.branch_pc),
    .jump_en_i     (jump_en),
    .jump_req_i    (bus.jump_req),
    .jump_pc_i     (bus.jump_pc),
    .hold_i        (hold),
    .pc_next_o     (pc_next),
    .pc_plus1_o    (pc_plus1),
    .redirect_o    (redirect)
  );

  assign halt_hit = (bus.opcode == HALT_OP) && fetch_valid_q;

  always_comb begin
    state_d       = state_q;
    fetch_valid_d = 1'b0;
    halted_d      = halted_q;
    branch_en     = 1'b0;
    jump_en       = 1'b0;
    hold          = 1'b1;
    flush         = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d       = ST_RUN;
        fetch_valid_d = 1'b1;
      end
      ST_RUN: begin
        branch_en = 1'b1;
        jump_en   = 1'b1;
        flush     = bus.branch_taken || bus.jump_req;
        hold      = bus.hazard || halt_hit;
        if (redirect) begin
          state_d = ST_REDIR;
        end else if (bus.hazard) begin
          fetch_valid_d = 1'b1;
        end else if (halt_hit) begin
          state_d  = ST_HALT;
          halted_d = 1'b1;
        end else begin
`ifdef FETCH_STEP_EN
          state_d = ST_STEP_WAIT;
`else
          fetch_valid_d = 1'b1;
`endif
        end
      end
      // Squashed slot: only a new branch can redirect, hazard and jump never hold pc.
      ST_REDIR: begin
        branch_en = 1'b1;
        hold      = 1'b0;
        flush     = bus.branch_taken || bus.jump_req;
        if (!redirect) begin
          state_d       = ST_RUN;
          fetch_valid_d = 1'b1;
        end
      end
`ifdef FETCH_STEP_EN
      ST_STEP_WAIT: begin
        branch_en = 1'b1;
        jump_en   = 1'b1;
        flush     = bus.branch_taken || bus.jump_req;
        if (redirect) begin
          state_d = ST_REDIR;
        end else if (bus.step) begin
          state_d       = ST_RUN;
          fetch_valid_d = 1'b1;
        end
      end
`endif
      default: ;
    endcase
    pc_d = pc_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      fetch_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      halted_q      <= halted_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pc_plus1    = pc_plus1;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.halted      = halted_q;
  assign bus.flush       = flush && !reset;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a reference model pushes expected
// outputs per driven cycle; they are popped and compared after the clock edge.
module tb_fetch_sequencer;

  localparam int unsigned PC_W = 10;
`ifdef FETCH_STEP_EN
  localparam bit STEP_MODE = 1'b1;
`else
  localparam bit STEP_MODE = 1'b0;
`endif
  localparam int M_BOOT = 0, M_RUN = 1, M_REDIR = 2, M_HALT = 3, M_STEP = 4;

  typedef struct {
    logic [PC_W-1:0] pc;
    logic            fv;
    logic            h;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.PC_W(PC_W)) bus ();

  fetch_sequencer #(.PC_W(PC_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  logic            d_reset, d_hz, d_bt, d_jr, d_step;
  logic [PC_W-1:0] d_bpc, d_jpc;
  logic [5:0]      d_op;

  logic [PC_W-1:0] m_pc;
  int              m_st;
  logic            m_fv, m_h;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    d_reset = 1'b0; d_hz = 1'b0; d_bt = 1'b0; d_jr = 1'b0; d_step = 1'b0;
    d_bpc = '0; d_jpc = '0; d_op = 6'h00;
  endtask

  task automatic model(output logic fl);
    fl = 1'b0;
    if (d_reset) begin
      m_pc = '0; m_st = M_BOOT; m_fv = 1'b0; m_h = 1'b0;
      return;
    end
    case (m_st)
      M_BOOT: begin m_st = M_RUN; m_fv = 1'b1; end
      M_RUN, M_STEP: begin
        fl = d_bt | d_jr;
        if (d_bt) begin m_pc = d_bpc; m_st = M_REDIR; m_fv = 1'b0; end
        else if (d_jr) begin m_pc = d_jpc; m_st = M_REDIR; m_fv = 1'b0; end
        else if (m_st == M_STEP) begin
          if (d_step) begin m_st = M_RUN; m_fv = 1'b1; end
        end
        else if (d_hz) m_fv = 1'b1;
        else if (d_op == 6'h3F && m_fv) begin m_st = M_HALT; m_fv = 1'b0; m_h = 1'b1; end
        else begin
          m_pc = m_pc + 10'd1;
          if (STEP_MODE) begin m_st = M_STEP; m_fv = 1'b0; end
          else m_fv = 1'b1;
        end
      end
      M_REDIR: begin
        fl = d_bt | d_jr;
        if (d_bt) begin m_pc = d_bpc; m_fv = 1'b0; end
        else begin m_pc = m_pc + 10'd1; m_st = M_RUN; m_fv = 1'b1; end
      end
      default: ;
    endcase
  endtask

  task automatic tick();
    exp_t            e;
    logic            exp_fl;
    logic [PC_W-1:0] exp_p1;
    @(negedge clk);
    reset            = d_reset;
    bus.hazard       = d_hz;
    bus.branch_taken = d_bt;
    bus.branch_pc    = d_bpc;
    bus.jump_req     = d_jr;
    bus.jump_pc      = d_jpc;
    bus.opcode       = d_op;
    bus.step         = d_step;
    #1;
    model(exp_fl);
    chk("flush", {31'd0, bus.flush}, {31'd0, exp_fl});
    e.pc = m_pc; e.fv = m_fv; e.h = m_h;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      exp_p1 = e.pc + 10'd1;
      chk("pc", {22'd0, bus.pc}, {22'd0, e.pc});
      chk("pc_plus1", {22'd0, bus.pc_plus1}, {22'd0, exp_p1});
      chk("fetch_valid", {31'd0, bus.fetch_valid}, {31'd0, e.fv});
      chk("halted", {31'd0, bus.halted}, {31'd0, e.h});
    end
  endtask

  initial begin
    int unsigned p;
    idle();
    m_pc = '0; m_st = M_BOOT; m_fv = 1'b0; m_h = 1'b0;

    d_reset = 1'b1; tick(); tick();
    chk("rst_pc", {22'd0, bus.pc}, 32'd0);
    chk("rst_fv", {31'd0, bus.fetch_valid}, 32'd0);
    chk("rst_halted", {31'd0, bus.halted}, 32'd0);
    d_reset = 1'b0;

`ifndef FETCH_STEP_EN
    tick();
    chk("t1_run0_pc", {22'd0, bus.pc}, 32'd0);
    chk("t1_run0_fv", {31'd0, bus.fetch_valid}, 32'd1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("t1_inc", {22'd0, bus.pc}, i);
    end

    tick(); tick();
    chk("t2_start", {22'd0, bus.pc}, 32'd5);
    d_hz = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_hold", {22'd0, bus.pc}, 32'd5);
    end
    idle(); tick();
    chk("t2_release", {22'd0, bus.pc}, 32'd6);

    tick(); tick();
    chk("t3_start", {22'd0, bus.pc}, 32'd8);
    d_bt = 1'b1; d_bpc = 10'h040; tick(); idle();
    chk("t3_target", {22'd0, bus.pc}, 32'h40);
    chk("t3_bubble", {31'd0, bus.fetch_valid}, 32'd0);
    tick();
    chk("t3_after", {22'd0, bus.pc}, 32'h41);

    d_bt = 1'b1; d_bpc = 10'h002; tick(); idle(); tick();
    chk("t4_start", {22'd0, bus.pc}, 32'd3);
    d_bt = 1'b1; d_bpc = 10'h020; d_jr = 1'b1; d_jpc = 10'h100; tick(); idle();
    chk("t4_branch_wins", {22'd0, bus.pc}, 32'h20);

    d_bt = 1'b1; d_bpc = 10'h030; tick(); idle();
    chk("redir_rebranch", {22'd0, bus.pc}, 32'h30);
    tick();
    d_jr = 1'b1; d_jpc = 10'h100; tick(); idle();
    chk("jump_target", {22'd0, bus.pc}, 32'h100);
    d_hz = 1'b1; tick(); idle();
    chk("redir_hazard_ignored", {22'd0, bus.pc}, 32'h101);

    d_bt = 1'b1; d_bpc = 10'h3FE; tick(); idle(); tick();
    chk("t5_top", {22'd0, bus.pc}, 32'h3FF);
    tick();
    chk("t5_wrap", {22'd0, bus.pc}, 32'h000);
    d_op = 6'h3F; tick(); idle();
    chk("t5_halted", {31'd0, bus.halted}, 32'd1);
    d_bt = 1'b1; d_bpc = 10'h055; d_jr = 1'b1; tick(); idle();
    for (int i = 0; i < 3; i++) tick();
    chk("t5_frozen", {22'd0, bus.pc}, 32'h000);
    d_reset = 1'b1; tick(); d_reset = 1'b0;
    chk("t5_reset_exit", {31'd0, bus.halted}, 32'd0);
`else
    tick(); tick();
    p = bus.pc;
    chk("t6_first_adv", p, 32'd1);
    for (int i = 0; i < 5; i++) tick();
    chk("t6_no_step", {22'd0, bus.pc}, p);
    for (int i = 0; i < 3; i++) begin
      d_step = 1'b1; tick(); d_step = 1'b0; tick(); tick();
    end
    chk("t6_three_steps", {22'd0, bus.pc}, p + 3);
`endif

    for (int i = 0; i < 400; i++) begin
      d_reset = ($urandom_range(0, 49) == 0);
      d_hz    = ($urandom_range(0, 6) == 0);
      d_bt    = ($urandom_range(0, 9) == 0);
      d_jr    = ($urandom_range(0, 9) == 0);
      d_step  = ($urandom_range(0, 2) == 0);
      d_bpc   = PC_W'($urandom);
      d_jpc   = PC_W'($urandom);
      d_op    = ($urandom_range(0, 29) == 0) ? 6'h3F : 6'($urandom_range(0, 62));
      tick();
    end
    idle();

    chk("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
